conv_accum_ctrl: RTL
====================

Name: conv_accum_ctrl

Overview:
Sequences the multi-chunk accumulation of one convolution output sample. The combinational adder tree reduces N_REG products to one partial sum per chunk. This block accepts one partial sum per chunk over a valid/ready handshake, accumulates the chunks with guard bits on top of a bias, saturates to Q(WIDTH-FBITS).FBITS, and presents the result on a valid/ready output. It sits between the multiplier-array/adder-tree datapath and the layer output writer.

Parameters:
WIDTH, 32, data word width (signed two's complement fixed point)
FBITS, 24, fractional bits; informational only, no rescaling is performed
N_REG, 31, products per chunk reduced upstream; informational, carried for config checks
CNT_W, 8, width of the chunk counter; max job length is 2^CNT_W-1 chunks

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  job start request, sampled only in IDLE
n_chunks  in  CNT_W  number of partial sums in the job, latched on start
bias  in  WIDTH  signed bias, latched on start as accumulator initial value
busy  out  1  high whenever state is not IDLE
psum  in  WIDTH  signed partial sum from the adder tree
in_valid  in  1  psum valid
in_ready  out  1  block accepts psum
y  out  WIDTH  saturated result, registered
out_valid  out  1  y valid
out_ready  in  1  downstream accepts y
sat_flag  out  1  y was clipped; registered with y
done  out  1  one-cycle pulse after the output handshake

Behaviour:
- Reset is asynchronous and active-low on rst_n, with one clock clk. Assertion at any time, including mid-job, immediately forces:
  - state=IDLE, acc=0, cnt=0
  - busy=0, in_ready=0, out_valid=0, y=0, sat_flag=0, done=0
  - The in-flight job is discarded.
- Accumulator acc is ACC_W = WIDTH+CNT_W+1 bits signed. Inputs are sign-extended. No overflow is possible inside acc.
- The state machine is registered. in_ready and busy decode from state only, with no combinational path from in_valid or out_ready.
- IDLE:
  - start=1 latches n_chunks into len, sets acc <= sext(bias), cnt <= 0.
  - Goes to ACCUM if len>0, else to SAT.
- ACCUM:
  - in_ready=1.
  - On in_valid&in_ready: acc <= acc + sext(psum), cnt <= cnt+1.
  - If cnt==len-1 at the accept, go to SAT. Otherwise stay.
  - in_valid low holds everything.
- SAT (1 cycle, in_ready=0):
  - If acc > 2^(WIDTH-1)-1: y <= 2^(WIDTH-1)-1, sat_flag <= 1.
  - Else if acc < -2^(WIDTH-1): y <= -2^(WIDTH-1), sat_flag <= 1.
  - Else: y <= acc[WIDTH-1:0], sat_flag <= 0.
  - out_valid <= 1. Go to OUT.
- OUT:
  - y, sat_flag and out_valid are held stable until out_valid&out_ready.
  - On that edge: out_valid <= 0, done <= 1, go to IDLE.
  - out_ready already high on entry completes the handshake in the first OUT cycle.
- done is high for exactly the first IDLE cycle after a handshake. A start in that cycle is accepted (back-to-back jobs).
- y and sat_flag keep their last value after the handshake until the next SAT.
- start outside IDLE is ignored. It is not queued.
- Latency:
  - out_valid rises on the edge after the accept edge of the last chunk.
  - For len=0, out_valid rises 2 edges after the start edge (IDLE→SAT→OUT).
- Minimum job time is len + 2 cycles plus downstream stall. Max throughput is 1 chunk/cycle in ACCUM.

Test Plan:
1. Q8.24 job: bias=0x00800000 (0.5), n_chunks=3, psum=0x01000000, 0x02000000, 0xFFC00000 on consecutive cycles, out_ready=1 → y=0x03400000 (3.25), sat_flag=0. out_valid is high 1 edge after the 3rd accept and lasts 1 cycle. done pulses the next cycle.
2. Saturation: bias=0, n_chunks=2, psum=0x7F000000 twice → y=0x7FFFFFFF, sat_flag=1. Repeat with 0x80000000 twice → y=0x80000000, sat_flag=1.
3. Backpressure:
   - n_chunks=4, in_valid toggles 1,0,1,0,1,1 → exactly 4 accepts, and in_ready=0 after the 4th.
   - Then out_ready=0 for 5 cycles → y, sat_flag and out_valid are stable, with no done.
   - Then out_ready=1 → done pulse.
4. Zero-length job: bias=0xFF000000, n_chunks=0 → in_ready never asserts. y=0xFF000000 and out_valid=1 are observed 2 edges after start.
5. Reset mid-job: rst_n low after 1 of 4 chunks accepted → all outputs 0 asynchronously. After release, a job with bias=0, n_chunks=1, psum=0x00100000 gives y=0x00100000.
6. Control races:
   - start pulsed while busy → ignored, and the result matches a single job.
   - start asserted in the done cycle → the new job starts that edge, with busy staying 1 from the next cycle.

Source files
------------

// File: rtl/conv_accum_ctrl.sv
// Chunked accumulation controller for one convolution output sample.
// Bias-seeded guard-bit accumulator, saturation to WIDTH bits, valid/ready on both sides.
module conv_accum_ctrl #(
    parameter int WIDTH = 32,
    parameter int FBITS = 24,
    parameter int N_REG = 31,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_chunks,
    input  logic [WIDTH-1:0] bias,
    output logic             busy,
    input  logic [WIDTH-1:0] psum,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sat_flag,
    output logic             done
);

    localparam int ACC_W = WIDTH + CNT_W + 1;

    generate
        if (FBITS < 0 || FBITS >= WIDTH || N_REG < 1 || CNT_W < 1) begin : g_bad_cfg
            $error("conv_accum_ctrl: inconsistent WIDTH/FBITS/N_REG/CNT_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_SAT,
        S_OUT
    } state_t;

    state_t                   state;
    state_t                   state_nx;
    logic [CNT_W-1:0]         len;
    logic [CNT_W-1:0]         cnt;
    logic signed [ACC_W-1:0]  acc;
    logic                     last_chunk;

    function automatic logic signed [ACC_W-1:0] sext(input logic [WIDTH-1:0] v);
        return {{(ACC_W-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    // Returns {clipped, value}; the value fits iff all bits above the sign bit agree.
    function automatic logic [WIDTH:0] saturate(input logic signed [ACC_W-1:0] a);
        logic [ACC_W-WIDTH:0] top;
        top = a[ACC_W-1:WIDTH-1];
        if (top == '0 || top == '1)
            return {1'b0, a[WIDTH-1:0]};
        else if (a[ACC_W-1])
            return {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    assign last_chunk = (cnt == len - CNT_W'(1));
    assign in_ready   = (state == S_ACCUM);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nx = (n_chunks != '0) ? S_ACCUM : S_SAT;
            end
            S_ACCUM: begin
                if (in_valid && last_chunk)
                    state_nx = S_SAT;
            end
            S_SAT: begin
                state_nx = S_OUT;
            end
            S_OUT: begin
                if (out_ready)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len       <= '0;
            cnt       <= '0;
            acc       <= '0;
            y         <= '0;
            sat_flag  <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len <= n_chunks;
                        acc <= sext(bias);
                        cnt <= '0;
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        acc <= acc + sext(psum);
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_SAT: begin
                    {sat_flag, y} <= saturate(acc);
                    out_valid     <= 1'b1;
                end
                S_OUT: begin
                    // y and sat_flag intentionally persist past the handshake
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
